// File: rtl/vga_sync_if.sv
// VGA timing bundle: sync, blanking qualifier, pixel coordinates and strobes.
interface vga_sync_if;
    logic       pixel_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;

    modport master (
        output pixel_tick,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_start
    );

    modport slave (
        input pixel_tick,
        input hsync,
        input vsync,
        input video_on,
        input pixel_x,
        input pixel_y,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA sync generator: runs on clk_50 with an internal pixel-rate enable and
// produces hsync/vsync, video_on, pixel coordinates and a frame-start pulse.
// Every register updates on the edge that raises pixel_tick, so pixel_tick,
// the coordinates and frame_start are all seen together in the same cycle.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk_50,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_FRONT_AT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_AT  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BACK_AT  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FRONT_AT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_AT  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BACK_AT  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

    localparam logic [1:0] H_ACT   = 2'd0;
    localparam logic [1:0] H_FRONT = 2'd1;
    localparam logic [1:0] H_SYNCP = 2'd2;
    localparam logic [1:0] H_BACK  = 2'd3;
    localparam logic [1:0] V_ACT   = 2'd0;
    localparam logic [1:0] V_FRONT = 2'd1;
    localparam logic [1:0] V_SYNCP = 2'd2;
    localparam logic [1:0] V_BACK  = 2'd3;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]       h_state_q, h_state_d;
    logic [1:0]       v_state_q, v_state_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap_c;
    logic             v_wrap_c;

    assign h_wrap_c = (h_cnt_q == H_LAST);
    assign v_wrap_c = (v_cnt_q == V_LAST);

    // Next-state: divider, horizontal/vertical FSMs and registered outputs
    always_comb begin
        div_cnt_d     = div_cnt_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_state_d     = h_state_q;
        v_state_d     = v_state_q;
        run_d         = run_q;
        tick_d        = 1'b0;
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        video_on_d    = 1'b0;
        frame_start_d = 1'b0;

        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        tick_d    = (div_cnt_d == DIV_LAST);

        if (tick_d) begin
            run_d   = 1'b1;
            h_cnt_d = h_wrap_c ? '0 : h_cnt_q + CNT_W'(1);
            case (h_state_q)
                H_ACT:   if (h_cnt_d == H_FRONT_AT) h_state_d = H_FRONT;
                H_FRONT: if (h_cnt_d == H_SYNC_AT)  h_state_d = H_SYNCP;
                H_SYNCP: if (h_cnt_d == H_BACK_AT)  h_state_d = H_BACK;
                H_BACK:  if (h_wrap_c)              h_state_d = H_ACT;
                default:                            h_state_d = H_ACT;
            endcase

            if (h_wrap_c) begin
                v_cnt_d = v_wrap_c ? '0 : v_cnt_q + CNT_W'(1);
                case (v_state_q)
                    V_ACT:   if (v_cnt_d == V_FRONT_AT) v_state_d = V_FRONT;
                    V_FRONT: if (v_cnt_d == V_SYNC_AT)  v_state_d = V_SYNCP;
                    V_SYNCP: if (v_cnt_d == V_BACK_AT)  v_state_d = V_BACK;
                    V_BACK:  if (v_wrap_c)              v_state_d = V_ACT;
                    default:                            v_state_d = V_ACT;
                endcase
            end

            frame_start_d = h_wrap_c && v_wrap_c;
        end

        hsync_d    = (h_state_d == H_SYNCP) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = (v_state_d == V_SYNCP) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (h_state_d == H_ACT) && (v_state_d == V_ACT) && run_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_50) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_state_q     <= H_ACT;
            v_state_q     <= V_ACT;
            run_q         <= 1'b0;
            tick_q        <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            run_q         <= run_d;
            tick_q        <= tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pixel_tick  = tick_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = h_cnt_q;
    assign vga.pixel_y     = v_cnt_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances with shrunken timing (CLK_DIV=2
// active-low and CLK_DIV=4 active-high) checked every cycle against a model
// that derives the raster position from elapsed cycles since reset.
module tb_vga_sync_gen;

    localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int unsigned VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned DIV_A = 2;
    localparam int unsigned DIV_B = 4;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned t        = 0;

    vga_sync_if if_a ();
    vga_sync_if if_b ();

    vga_sync_gen #(
        .CLK_DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut_a (
        .clk_50(clk_50),
        .reset (reset),
        .vga   (if_a.master)
    );

    vga_sync_gen #(
        .CLK_DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
    ) dut_b (
        .clk_50(clk_50),
        .reset (reset),
        .vga   (if_b.master)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Pixel ticks seen so far at cycle tt since reset
    function automatic int unsigned ticks(input int unsigned tt, input int unsigned div);
        return (tt + 1) / div;
    endfunction

    // Linear raster position (0 .. HT*VT-1) at cycle tt
    function automatic int unsigned pos(input int unsigned tt, input int unsigned div);
        return ticks(tt, div) % (HT * VT);
    endfunction

    task automatic check_dut(input string nm, input int unsigned div, input logic pol,
                             input logic tick, input logic hs, input logic vs,
                             input logic vo, input logic fs,
                             input logic [9:0] px, input logic [9:0] py);
        int unsigned n, p, x, y;
        logic e_tick, e_hs, e_vs, e_vo, e_fs;
        n      = ticks(t, div);
        p      = pos(t, div);
        x      = p % HT;
        y      = p / HT;
        e_tick = ((t + 1) % div) == 0;
        e_hs   = (x >= HA + HF && x < HA + HF + HS) ? pol : ~pol;
        e_vs   = (y >= VA + VF && y < VA + VF + VS) ? pol : ~pol;
        e_vo   = (x < HA) && (y < VA) && (n >= 1);
        e_fs   = e_tick && (p == 0) && (n >= 1);
        chk({nm, ".pixel_tick"},  32'(tick), 32'(e_tick));
        chk({nm, ".hsync"},       32'(hs),   32'(e_hs));
        chk({nm, ".vsync"},       32'(vs),   32'(e_vs));
        chk({nm, ".video_on"},    32'(vo),   32'(e_vo));
        chk({nm, ".frame_start"}, 32'(fs),   32'(e_fs));
        chk({nm, ".pixel_x"},     32'(px),   32'(x));
        chk({nm, ".pixel_y"},     32'(py),   32'(y));
    endtask

    // One clock with the given reset level, then model update and full check
    task automatic step(input logic rst);
        reset = rst;
        @(posedge clk_50);
        #1;
        t = rst ? 0 : t + 1;
        check_dut("A", DIV_A, 1'b0, if_a.pixel_tick, if_a.hsync, if_a.vsync,
                  if_a.video_on, if_a.frame_start, if_a.pixel_x, if_a.pixel_y);
        check_dut("B", DIV_B, 1'b1, if_b.pixel_tick, if_b.hsync, if_b.vsync,
                  if_b.video_on, if_b.frame_start, if_b.pixel_x, if_b.pixel_y);
    endtask

    // Advance until instance A's model sits at (tx, ty); bounded by one frame
    task automatic seek_a(input int unsigned tx, input int unsigned ty, output bit found);
        found = 1'b0;
        for (int i = 0; i < int'(HT * VT * DIV_A + 8); i++) begin
            if (pos(t, DIV_A) == ty * HT + tx) begin
                found = 1'b1;
                break;
            end
            step(1'b0);
        end
    endtask

    initial begin
        bit found;

        // Reset state
        step(1'b1);
        step(1'b1);
        chk("rst.A.hsync",    32'(if_a.hsync),       32'd1);
        chk("rst.A.vsync",    32'(if_a.vsync),       32'd1);
        chk("rst.B.hsync",    32'(if_b.hsync),       32'd0);
        chk("rst.B.vsync",    32'(if_b.vsync),       32'd0);
        chk("rst.A.video_on", 32'(if_a.video_on),    32'd0);
        chk("rst.A.tick",     32'(if_a.pixel_tick),  32'd0);
        chk("rst.A.fs",       32'(if_a.frame_start), 32'd0);
        chk("rst.A.pixel_x",  32'(if_a.pixel_x),     32'd0);

        // First tick after release: position 1 becomes visible
        step(1'b0);
        chk("rel.A.tick",     32'(if_a.pixel_tick),  32'd1);
        chk("rel.A.pixel_x",  32'(if_a.pixel_x),     32'd1);
        chk("rel.A.video_on", 32'(if_a.video_on),    32'd1);
        chk("rel.B.tick",     32'(if_b.pixel_tick),  32'd0);

        // Free run past two A frames and one B frame
        for (int i = 0; i < 4000; i++) step(1'b0);

        // Wrap corner on A: (HT-1, VT-1) -> (0, 0) with frame_start
        seek_a(HT - 1, VT - 1, found);
        chk("seek.corner", 32'(found), 32'd1);
        for (int i = 0; i < int'(DIV_A) && pos(t, DIV_A) != 0; i++) step(1'b0);
        chk("wrap.A.pixel_x", 32'(if_a.pixel_x),     32'd0);
        chk("wrap.A.pixel_y", 32'(if_a.pixel_y),     32'd0);
        chk("wrap.A.fs",      32'(if_a.frame_start), 32'd1);
        step(1'b0);
        chk("wrap.A.fs_end",  32'(if_a.frame_start), 32'd0);

        // Reset asserted mid-hsync on A
        seek_a(HA + HF + 2, 5, found);
        chk("seek.midsync", 32'(found), 32'd1);
        chk("mid.A.hsync_low", 32'(if_a.hsync), 32'd0);
        step(1'b1);
        chk("mid.A.hsync",    32'(if_a.hsync),    32'd1);
        chk("mid.A.vsync",    32'(if_a.vsync),    32'd1);
        chk("mid.A.video_on", 32'(if_a.video_on), 32'd0);
        chk("mid.A.pixel_x",  32'(if_a.pixel_x),  32'd0);
        chk("mid.A.pixel_y",  32'(if_a.pixel_y),  32'd0);
        chk("mid.B.hsync",    32'(if_b.hsync),    32'd0);
        for (int i = 0; i < 2500; i++) step(1'b0);

        // Random reset pulses at random phases
        for (int r = 0; r < 6; r++) begin
            int unsigned run_len, rst_len;
            run_len = $urandom_range(1500, 200);
            rst_len = $urandom_range(3, 1);
            for (int i = 0; i < int'(run_len); i++) step(1'b0);
            for (int i = 0; i < int'(rst_len); i++) step(1'b1);
        end

        // Long tail to cover full frames after the last random reset
        for (int i = 0; i < 4000; i++) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
